uart_tx_buffered: RTL and testbench

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_tx_buffered.sv | 157 +++++++++++++++
 tb/tb_uart_tx_buffered.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Byte FIFO feeding an 8N1 UART serializer. Serial, active and done outputs are registered,
// with each value computed from the serializer's next state.
module uart_tx_buffered #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Tx_DV,
  input  logic [7:0]                    i_Tx_Byte,
  output logic                          o_Full,
  output logic                          o_Empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_Count,
  output logic                          o_Overflow,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          head_vld_q, head_vld_d;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          serial_q, serial_d;
  logic          active_q, active_d;
  logic          done_q, done_d;

  logic full, wr_en, pop, baud_last;

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign wr_en     = i_Tx_DV & ~full;
  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

  // FIFO bookkeeping; head_vld_q lags the count so a fresh byte is seen one cycle later.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q | (i_Tx_DV & full);
    head_vld_d = (count_q != '0);
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (head_vld_q && (count_q != '0)) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          baud_d  = '0;
          bit_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d = '0;
          bit_d  = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = StStop;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = StIdle;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    unique case (state_d)
      StStart: serial_d = 1'b0;
      StData:  serial_d = data_d[bit_d];
      default: serial_d = 1'b1;
    endcase
    active_d = (state_d != StIdle);
    done_d   = (state_d == StStop) && (baud_d == BW'(CLKS_PER_BIT - 1));
  end

  always_ff @(posedge i_Clock) begin
    if (wr_en && !i_Reset) mem_q[wr_ptr_q] <= i_Tx_Byte;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      head_vld_q <= 1'b0;
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      head_vld_q <= head_vld_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      serial_q   <= serial_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  assign o_Full      = full;
  assign o_Empty     = (count_q == '0);
  assign o_Count     = count_q;
  assign o_Overflow  = ovf_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: timeline/queue reference model compared every cycle, a line
// decoder, and directed scenarios with literal expectations followed by random traffic.
module tb_uart_tx_buffered;
  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int          FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dv  = 1'b0;
  logic [7:0] din = 8'h00;
  logic       o_full, o_empty, o_ovf, o_active, o_serial, o_done;
  logic [2:0] o_count;

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv), .i_Tx_Byte(din),
    .o_Full(o_full), .o_Empty(o_empty), .o_Count(o_count), .o_Overflow(o_ovf),
    .o_Tx_Active(o_active), .o_Tx_Serial(o_serial), .o_Tx_Done(o_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: entries carry their write edge; a byte may be taken two edges after
  // it was written. A frame is a timeline t = edges since the pop (0..FRAME-1 on the line).
  logic [7:0] mq_b[$];
  int         mq_e[$];
  int         cyc = 0;
  bit         m_ovf = 0, m_busy = 0, can_pop, do_pop, do_push;
  int         m_t = 0;
  logic [7:0] m_byte = 8'h00;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mq_b.delete(); mq_e.delete();
      m_ovf = 0; m_busy = 0; m_t = 0;
    end else begin
      can_pop = !m_busy || m_t >= FRAME;
      do_pop  = can_pop && mq_b.size() > 0 && mq_e[0] <= cyc - 2;
      do_push = dv && mq_b.size() < DEPTH;
      if (dv && mq_b.size() == DEPTH) m_ovf = 1;
      if (m_busy) m_t++;
      if (do_pop) begin
        m_byte = mq_b.pop_front();
        void'(mq_e.pop_front());
        m_busy = 1; m_t = 0;
      end else if (m_busy && m_t > FRAME) begin
        m_busy = 0;
      end
      if (do_push) begin
        mq_b.push_back(din);
        mq_e.push_back(cyc);
      end
    end
  end

  function automatic bit m_on_line();
    return m_busy && m_t < FRAME;
  endfunction

  function automatic logic exp_serial();
    int k;
    if (!m_on_line()) return 1'b1;
    k = m_t / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("serial", o_serial, exp_serial());
      chk("active", o_active, m_on_line());
      chk("done",   o_done,   m_busy && m_t == FRAME - 1);
      chk("count",  o_count,  mq_b.size());
      chk("full",   o_full,   mq_b.size() == DEPTH);
      chk("empty",  o_empty,  mq_b.size() == 0);
      chk("ovf",    o_ovf,    m_ovf);
    end
  end

  // Line decoder, sampled just after each edge.
  logic [7:0] rx_q[$];
  bit         rx_busy = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'h00;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      rx_busy = 0;
    end else if (!rx_busy) begin
      if (o_serial === 1'b0) begin rx_busy = 1; rx_cnt = 0; end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == 0 && rx_cnt / CPB <= 8) rx_sh[rx_cnt/CPB-1] = o_serial;
      if (rx_cnt == 9 * CPB) begin
        chk("rx_stop", o_serial, 1'b1);
        rx_q.push_back(rx_sh);
        rx_busy = 0;
      end
    end
  end

  function automatic logic [7:0] rx_at(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 8'hxx;
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1; dv = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    rx_q.delete();
  endtask

  task automatic drain();
    int n = 0;
    while ((mq_b.size() != 0 || m_on_line()) && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got busy expected idle at %0t", $time);
    end
    repeat (3) @(negedge clk);
  endtask

  bit         exp1 [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
  bit         got1 [10];
  int         act_cnt, done_cnt, n;
  logic [2:0] c1, c2, c3;
  logic [7:0] s6 [9];

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    cmp_en = 1;
    chk("reset_serial", o_serial, 1'b1);
    chk("reset_empty", o_empty, 1'b1);
    chk("reset_count", o_count, 3'd0);

    // Scenario 1: single byte 0x41 from idle.
    do_reset();
    @(negedge clk); dv = 1; din = 8'h41;
    @(negedge clk); dv = 0;
    chk("s1_line_after_n", o_serial, 1'b1);
    @(negedge clk); chk("s1_line_after_n1", o_serial, 1'b1);
    @(negedge clk); chk("s1_line_after_n2", o_serial, 1'b0);
    act_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 45; c++) begin
      if (c % CPB == 0 && c < FRAME) got1[c/CPB] = o_serial;
      act_cnt += int'(o_active);
      done_cnt += int'(o_done);
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++) chk($sformatf("s1_bit%0d", i), got1[i], exp1[i]);
    chk("s1_active_cycles", act_cnt, 40);
    chk("s1_done_pulses", done_cnt, 1);
    chk("s1_rx_byte", rx_at(0), 8'h41);

    // Scenario 2: three consecutive writes.
    do_reset();
    @(negedge clk); dv = 1; din = 8'h55;
    @(negedge clk); c1 = o_count; din = 8'hAA;
    @(negedge clk); c2 = o_count; din = 8'h0F;
    @(negedge clk); c3 = o_count; dv = 0;
    chk("s2_count1", c1, 3'd1);
    chk("s2_count2", c2, 3'd2);
    chk("s2_count3", c3, 3'd2);
    drain();
    chk("s2_frames", rx_q.size(), 3);
    chk("s2_b0", rx_at(0), 8'h55);
    chk("s2_b1", rx_at(1), 8'hAA);
    chk("s2_b2", rx_at(2), 8'h0F);

    // Scenario 3: six writes while the first frame transmits.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) chk("s3_full_after5", o_full, 1'b1);
      dv = 1; din = 8'h10 + 8'(i);
    end
    @(negedge clk); dv = 0;
    chk("s3_ovf", o_ovf, 1'b1);
    chk("s3_count", o_count, 3'd4);
    drain();
    chk("s3_frames", rx_q.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("s3_b%0d", i), rx_at(i), 8'h10 + 8'(i));

    // Scenario 4: reset at cycle 15 of a frame (with overflow set and FIFO full).
    do_reset();
    for (int i = 0; i < 6; i++) begin @(negedge clk); dv = 1; din = 8'hC0 + 8'(i); end
    @(negedge clk); dv = 0;
    repeat (11) @(negedge clk);
    chk("s4_pre_active", o_active, 1'b1);
    chk("s4_pre_ovf", o_ovf, 1'b1);
    rst = 1; dv = 1; din = 8'h99;
    @(negedge clk);
    chk("s4_serial", o_serial, 1'b1);
    chk("s4_count", o_count, 3'd0);
    chk("s4_ovf", o_ovf, 1'b0);
    rst = 0; dv = 0;
    rx_q.delete();
    act_cnt = 0;
    repeat (100) begin @(negedge clk); act_cnt += int'(o_active); end
    chk("s4_no_activity", act_cnt, 0);
    chk("s4_no_frames", rx_q.size(), 0);

    // Scenario 5: write while full on the very edge the serializer pops.
    do_reset();
    for (int i = 0; i < 5; i++) begin @(negedge clk); dv = 1; din = 8'h20 + 8'(i); end
    @(negedge clk); dv = 0;
    n = 0;
    while (!(m_busy && m_t == FRAME) && n < 200) begin @(negedge clk); n++; end
    chk("s5_sync_found", n < 200, 1'b1);
    chk("s5_pre_count", o_count, 3'd4);
    chk("s5_pre_ovf", o_ovf, 1'b0);
    dv = 1; din = 8'hEE;
    @(negedge clk); dv = 0;
    chk("s5_count", o_count, 3'd3);
    chk("s5_ovf", o_ovf, 1'b1);
    drain();
    chk("s5_frames", rx_q.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("s5_b%0d", i), rx_at(i), 8'h20 + 8'(i));

    // Scenario 6: nine spaced writes so the pointers wrap twice.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      s6[i] = 8'($urandom);
      @(negedge clk); dv = 1; din = s6[i];
      @(negedge clk); dv = 0;
      repeat (43) @(negedge clk);
    end
    drain();
    chk("s6_frames", rx_q.size(), 9);
    for (int i = 0; i < 9; i++) chk($sformatf("s6_b%0d", i), rx_at(i), s6[i]);

    // Random traffic with bursts and occasional resets.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 399) == 0);
      dv  = ($urandom_range(0, 15) < ((i / 250) % 2 == 0 ? 1 : 6));
      din = 8'($urandom);
    end
    @(negedge clk); rst = 0; dv = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
